// File: rtl/des_sbox_sequencer.sv
// -----------------------------------------------------------------------------
// des_sbox_sequencer
//
// Purpose:
//   Time-multiplexes one shared DES S-box lookup bank (S1..S8, selected by
//   index) across the eight 6-bit chunks of a 48-bit key-mixed round value.
//   Each chunk yields one 4-bit result.  The eight results are packed into the
//   32-bit substitution output that feeds the P-permutation.  One block is in
//   flight at a time.
//
// Parameters:
//   SBOX_LAT   bank read latency: 0 = combinational bank, 1 = registered bank.
//              Any non-zero value is treated as 1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous abort of the block in flight or the pending result
//   in_valid   in_data is valid
//   in_ready   sequencer can accept a block (IDLE and no flush)
//   in_data    48-bit value; [47:42] -> S1 ... [5:0] -> S8
//   out_valid  out_data is valid (DONE state)
//   out_ready  consumer accepts out_data
//   out_data   32-bit result; [31:28] from S1 ... [3:0] from S8
//   sbox_req   lookup issued this cycle
//   sbox_sel   box index 0 = S1 ... 7 = S8 (0 when sbox_req = 0)
//   sbox_in    raw 6-bit chunk (0 when sbox_req = 0)
//   sbox_out   bank result
//   busy       state is not IDLE
//   dbg_state  current FSM state encoding (observation only)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high.  A producer holds valid and data stable until that edge; ready may
// depend on state and flush but never on valid.
// -----------------------------------------------------------------------------
module des_sbox_sequencer #(
    parameter int SBOX_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        sbox_req,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_in,
    input  logic [3:0]  sbox_out,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam bit LAT_REG = (SBOX_LAT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_k;          // issue index during LOOKUP
    logic [47:0] r_data;       // latched input block
    logic [31:0] r_out;        // result nibbles, packed S1 in the top nibble
    logic        r_cap_pend;   // registered bank: a result arrives this cycle
    logic [2:0]  r_cap_idx;    // registered bank: index of the arriving result

    logic        w_accept;
    logic        w_out_hs;
    logic        w_issue;
    logic [5:0]  w_chunk;
    logic        w_cap_en;
    logic [2:0]  w_cap_idx;

    assign w_issue  = (r_state == ST_LOOKUP);
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

    // Chunk k of the latched block; S1 owns the most significant six bits.
    always_comb begin
        w_chunk = 6'd0;
        for (int j = 0; j < 8; j++) begin
            if (r_k == 3'(j)) begin
                w_chunk = r_data[47 - 6*j -: 6];
            end
        end
    end

    // With a combinational bank the result belongs to the index issued this
    // cycle; with a registered bank it belongs to the index issued one cycle
    // earlier.  flush suppresses any capture on its edge.
    always_comb begin
        if (LAT_REG) begin
            w_cap_en  = r_cap_pend && !flush;
            w_cap_idx = r_cap_idx;
        end else begin
            w_cap_en  = w_issue && !flush;
            w_cap_idx = r_k;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (r_k == 3'd7) begin
                    w_next = LAT_REG ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_out_hs) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (flush) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Issue index runs 0..7 during LOOKUP and rests at 0 elsewhere, so a new
    // block always starts at S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= 3'd0;
        end else if (flush || !w_issue) begin
            r_k <= 3'd0;
        end else begin
            r_k <= r_k + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 48'd0;
        end else if (w_accept) begin
            r_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_pend <= 1'b0;
            r_cap_idx  <= 3'd0;
        end else begin
            r_cap_pend <= w_issue && !flush;
            r_cap_idx  <= r_k;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 32'd0;
        end else begin
            for (int j = 0; j < 8; j++) begin
                if (w_cap_en && (w_cap_idx == 3'(j))) begin
                    r_out[31 - 4*j -: 4] <= sbox_out;
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !flush;
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_out;
    assign sbox_req  = w_issue;
    assign sbox_sel  = w_issue ? r_k : 3'd0;
    assign sbox_in   = w_issue ? w_chunk : 6'd0;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: doc/des_sbox_sequencer.md
Name: des_sbox_sequencer

Overview:
- Time-multiplexes one shared DES S-box lookup bank (S1..S8, selected by index) across the eight 6-bit chunks of a 48-bit key-mixed round value.
- Each 6-bit chunk maps to one 4-bit S-box result; the eight results are packed into the 32-bit f-function substitution output.
- Sits between the expansion/key-XOR stage and the P-permutation in the iterative DES round datapath.
- Valid/ready handshake on both sides; one block in flight.

Parameters:
- SBOX_LAT, 0, bank read latency in cycles. 0 = combinational bank (sbox_out valid in the same cycle as sel/in). 1 = registered bank (sbox_out valid one cycle later). Other values are illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; drops the block in flight or the pending result
- in_valid  input  1  in_data is valid
- in_ready  output  1  sequencer can accept a block
- in_data  input  48  [47:42] goes to S1 … [5:0] goes to S8
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- out_data  output  32  [31:28] from S1 … [3:0] from S8
- sbox_req  output  1  lookup issued this cycle
- sbox_sel  output  3  box index; 0 = S1 … 7 = S8
- sbox_in  output  6  raw 6-bit chunk; the bank applies its own row/column mapping
- sbox_out  input  4  bank result
- busy  output  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0
  - sbox_req=0, sbox_sel=0, sbox_in=0, busy=0
  - capture pointer=0, input holding register cleared
- States: IDLE, LOOKUP, DRAIN (only when SBOX_LAT=1), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (edge E0): latch in_data and go to LOOKUP with issue index k=0.
- LOOKUP:
  - sbox_req=1, sbox_sel=k, sbox_in=latched chunk k (S1 chunk is [47:42]).
  - k increments each cycle. After k=7 is issued: go to DONE if SBOX_LAT=0, or to DRAIN if SBOX_LAT=1.
- Capture:
  - Result for index j is written into out_data nibble [31-4j -: 4].
  - SBOX_LAT=0: captured on the same edge its lookup is issued.
  - SBOX_LAT=1: captured one edge later, tracked by a delayed index register.
- DRAIN:
  - sbox_req=0.
  - Captures the index-7 result, then goes to DONE.
- DONE:
  - out_valid=1; out_data is stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: go to IDLE. in_ready rises the next cycle; there is no same-cycle reload.
- Latency: out_valid rises 8+SBOX_LAT edges after E0. Minimum handshake-to-handshake period is 10+SBOX_LAT cycles.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored; no data is dropped because the producer must hold it.
- out_data resets to 0 and is only overwritten by captures. Partial nibbles are never visible because out_valid=0 until all eight are captured.
- sbox_sel and sbox_in return to 0 whenever sbox_req=0.
- flush:
  - From any state, next state is IDLE and out_valid drops.
  - Any result not yet handshaked is lost.
  - While flush=1, in_ready is forced to 0, so flush wins over a simultaneous input handshake.
  - If flush and out_valid&&out_ready occur together, the output handshake is considered completed (the consumer sampled the data) and the state is IDLE.
- Reset mid-operation: async return to reset values; no residual capture occurs on the first clock after release.
- busy = (state != IDLE).

Test Plan:
- SBOX_LAT=0, real DES bank model, in_data=48'h0 -> sbox_sel steps 0..7 on consecutive cycles; out_valid rises 8 edges after accept; out_data=32'hEFA72C4D.
- SBOX_LAT=0, stub bank returning sel+1, in_data=48'hFFFF_FFFF_FFFF -> out_data=32'h12345678; every sbox_in=6'h3F.
- S5 check, real bank: chunk 4 (in_data[23:18])=6'd21, all other chunks 0 -> out_data[15:12]=4'hF; other nibbles equal the all-zero-input values.
- SBOX_LAT=1, registered stub bank -> one DRAIN cycle with sbox_req=0; out_valid rises 9 edges after accept; out_data=32'h12345678.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0 throughout; second block accepted exactly one cycle after the output handshake.
- flush at issue index 3, then rst_n pulsed low during a later LOOKUP -> both return to IDLE; out_valid never asserts for the aborted blocks; all outputs at reset values; the next block completes correctly.
